ce_divider_bank: RTL and testbench

- Parametrised bank of independent clock-enable generators, all running from the system clock.
- Replaces the single hard-coded pixel-enable counter in the top-level with NUM_CH channels.
- Consumers: pixel CE, CPU CE (1/2 MHz overclock), ACIA baud CE, spare channels.
- Each channel has a runtime-selectable divisor, glitch-free divisor switching at period boundaries, per-channel pause, a global phase resync, and a mid-period (falling-phase) enable.

---
 rtl/ce_divider_bank.sv | 78 +++++++
 tb/tb_ce_divider_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ce_divider_bank.sv
// Bank of independent clock-enable generators with runtime divisors, pause,
// global phase resync and a mid-period (falling-phase) enable per channel.
module ce_divider_bank #(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int RESET_DIV = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    input  logic [NUM_CH-1:0]       pause_i,
    input  logic                    sync_i,
    output logic [NUM_CH-1:0]       ce_o,
    output logic [NUM_CH-1:0]       ce_n_o,
    output logic [NUM_CH-1:0]       pending_o
);

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_term;
        logic             r_ce;
        logic             r_ce_n;
        logic             r_pending;

        logic [DIV_W-1:0] w_div;
        logic [DIV_W-1:0] w_half;
        logic [DIV_W-1:0] w_cnt_next;
        logic [DIV_W-1:0] w_term_next;
        logic             w_ce_next;
        logic             w_ce_n_next;

        assign w_div  = div_i[n*DIV_W +: DIV_W];
        // Widened by one bit so an all-ones term does not overflow before halving.
        assign w_half = DIV_W'(({1'b0, r_term} + (DIV_W+1)'(1)) >> 1);

        always_comb begin
            w_cnt_next  = r_cnt;
            w_term_next = r_term;
            w_ce_next   = 1'b0;
            w_ce_n_next = 1'b0;
            if (sync_i) begin
                w_cnt_next  = '0;
                w_term_next = w_div;
            end else if (!pause_i[n]) begin
                if (r_cnt == r_term) begin
                    w_cnt_next  = '0;
                    w_term_next = w_div;
                    w_ce_next   = 1'b1;
                end else begin
                    w_cnt_next  = r_cnt + DIV_W'(1);
                end
                // Fires on the edge that moves cnt to half, i.e. half cycles after ce_o.
                w_ce_n_next = (r_term != '0) && (r_cnt == w_half - DIV_W'(1));
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt     <= '0;
                r_term    <= DIV_W'(RESET_DIV);
                r_ce      <= 1'b0;
                r_ce_n    <= 1'b0;
                r_pending <= 1'b0;
            end else begin
                r_cnt     <= w_cnt_next;
                r_term    <= w_term_next;
                r_ce      <= w_ce_next;
                r_ce_n    <= w_ce_n_next;
                r_pending <= (w_div != w_term_next);
            end
        end

        assign ce_o[n]      = r_ce;
        assign ce_n_o[n]    = r_ce_n;
        assign pending_o[n] = r_pending;
    end

endmodule

// File: tb/tb_ce_divider_bank.sv
// Self-checking bench for ce_divider_bank: directed scenarios plus random
// traffic, every cycle compared against a period/elapsed-time reference model.
module tb_ce_divider_bank;
  localparam int NUM_CH    = 4;
  localparam int DIV_W     = 8;
  localparam int RESET_DIV = 5;

  logic                    clk;
  logic                    reset;
  logic [NUM_CH*DIV_W-1:0] div_i;
  logic [NUM_CH-1:0]       pause_i;
  logic                    sync_i;
  logic [NUM_CH-1:0]       ce_o;
  logic [NUM_CH-1:0]       ce_n_o;
  logic [NUM_CH-1:0]       pending_o;

  ce_divider_bank #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .div_i     (div_i),
    .pause_i   (pause_i),
    .sync_i    (sync_i),
    .ce_o      (ce_o),
    .ce_n_o    (ce_n_o),
    .pending_o (pending_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: elapsed run cycles inside the current period, and its length
  int              m_el  [NUM_CH];
  int              m_per [NUM_CH];
  logic [NUM_CH-1:0] exp_ce;
  logic [NUM_CH-1:0] exp_ce_n;
  logic [NUM_CH-1:0] exp_pend;
  logic [31:0]     exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int div_of(int n);
    logic [NUM_CH*DIV_W-1:0] v;
    v = div_i;
    return int'(v[n*DIV_W +: DIV_W]);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NUM_CH; n++) begin
      m_el[n]  = 0;
      m_per[n] = RESET_DIV + 1;
    end
    exp_ce   = '0;
    exp_ce_n = '0;
    exp_pend = '0;
  endtask

  task automatic model_step();
    for (int n = 0; n < NUM_CH; n++) begin
      int d;
      d = div_of(n);
      if (reset) begin
        m_el[n] = 0; m_per[n] = RESET_DIV + 1;
        exp_ce[n] = 1'b0; exp_ce_n[n] = 1'b0; exp_pend[n] = 1'b0;
      end else if (sync_i) begin
        m_el[n] = 0; m_per[n] = d + 1;
        exp_ce[n] = 1'b0; exp_ce_n[n] = 1'b0; exp_pend[n] = 1'b0;
      end else if (pause_i[n]) begin
        exp_ce[n] = 1'b0; exp_ce_n[n] = 1'b0;
        exp_pend[n] = (d != m_per[n] - 1);
      end else begin
        m_el[n]++;
        exp_ce_n[n] = (m_per[n] > 1) && (m_el[n] == m_per[n] / 2);
        if (m_el[n] == m_per[n]) begin
          exp_ce[n] = 1'b1;
          m_el[n]   = 0;
          m_per[n]  = d + 1;
        end else begin
          exp_ce[n] = 1'b0;
        end
        exp_pend[n] = (d != m_per[n] - 1);
      end
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("ce_o", 32'(ce_o), 32'(exp_ce));
    check("ce_n_o", 32'(ce_n_o), 32'(exp_ce_n));
    check("pending_o", 32'(pending_o), 32'(exp_pend));
  endtask

  task automatic set_div(input int n, input int v);
    div_i[n*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  task automatic wait_el(input int n, input int el, input int per, input string tag);
    int k;
    k = 0;
    while (!(m_el[n] == el && m_per[n] == per) && k < 100) begin
      step();
      k++;
    end
    check(tag, 32'(k < 100), 32'd1);
  endtask

  task automatic steps_to_ce(input int n, input int limit, input int expected, input string tag);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!ce_o[n] && k < limit);
    check(tag, 32'(k), 32'(expected));
  endtask

  initial begin
    int first [NUM_CH];
    logic [NUM_CH-1:0] acc;
    int k;

    reset   = 1'b1;
    div_i   = '0;
    pause_i = '0;
    sync_i  = 1'b0;
    model_reset();
    for (int n = 0; n < NUM_CH; n++) set_div(n, 5);
    #2;
    check("reset_ce", 32'(ce_o), 32'd0);
    check("reset_ce_n", 32'(ce_n_o), 32'd0);
    check("reset_pending", 32'(pending_o), 32'd0);
    step();
    step();

    // run with divisor 5 on every channel
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("first_ce_not_early", 32'(ce_o), 32'd0);
    step();
    check("first_ce_all", 32'(ce_o), 32'hF);
    for (int i = 0; i < 3; i++) step();
    check("ce_n_at_3", 32'(ce_n_o), 32'hF);
    for (int i = 0; i < 12; i++) step();

    // ch0 divisor change mid-period
    wait_el(0, 2, 6, "wait_ch0_cnt2");
    set_div(0, 3);
    step();
    check("pending0_set", 32'(pending_o[0]), 32'd1);
    steps_to_ce(0, 20, 3, "ch0_old_period_kept");
    check("pending0_clear", 32'(pending_o[0]), 32'd0);
    steps_to_ce(0, 20, 4, "ch0_new_period");
    for (int i = 0; i < 8; i++) step();

    // ch1 divisor 0 and pause
    set_div(1, 0);
    for (int i = 0; i < 8; i++) step();
    check("ch1_div0_ce", 32'(ce_o[1]), 32'd1);
    pause_i[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("ch1_paused_ce", 32'(ce_o[1]), 32'd0);
    end
    pause_i[1] = 1'b0;
    step();
    check("ch1_resume_ce", 32'(ce_o[1]), 32'd1);

    // ch2 divisor 7, pause at cnt 4 stretches the period
    set_div(2, 7);
    wait_el(2, 4, 8, "wait_ch2_cnt4");
    pause_i[2] = 1'b1;
    acc = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      acc = acc | ce_o | ce_n_o;
    end
    check("ch2_pause_no_pulse", 32'(acc[2]), 32'd0);
    pause_i[2] = 1'b0;
    steps_to_ce(2, 20, 4, "ch2_after_pause");

    // global sync alignment
    set_div(0, 5); set_div(1, 3); set_div(2, 11); set_div(3, 5);
    k = $urandom_range(1, 20);
    for (int i = 0; i < k; i++) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    for (int n = 0; n < NUM_CH; n++) first[n] = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      for (int n = 0; n < NUM_CH; n++)
        if (ce_o[n] && first[n] == 0) first[n] = i;
    end
    exp_q.push_back(32'd6); exp_q.push_back(32'd4);
    exp_q.push_back(32'd12); exp_q.push_back(32'd6);
    for (int n = 0; n < NUM_CH; n++) check($sformatf("sync_first_ce_ch%0d", n), 32'(first[n]), exp_q.pop_front());
    sync_i = 1'b1;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      step();
      acc = acc | ce_o | ce_n_o;
    end
    check("sync_held_no_pulse", 32'(acc), 32'd0);
    sync_i = 1'b0;

    // random traffic
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_div($urandom_range(0, NUM_CH-1), ($urandom_range(0, 15) == 0) ? 255 : $urandom_range(0, 12));
      for (int n = 0; n < NUM_CH; n++) pause_i[n] = ($urandom_range(0, 7) == 0);
      sync_i = ($urandom_range(0, 39) == 0);
      step();
    end
    pause_i = '0;
    sync_i  = 1'b0;

    // maximum term: period 2^DIV_W
    set_div(3, 255);
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    steps_to_ce(3, 300, 256, "ch3_max_period");

    // asynchronous reset mid-period
    for (int n = 0; n < NUM_CH; n++) set_div(n, 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < NUM_CH; n++) set_div(n, 2);
    wait_el(0, 3, 6, "wait_ch0_cnt3");
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_ce", 32'(ce_o), 32'd0);
    check("async_reset_ce_n", 32'(ce_n_o), 32'd0);
    check("async_reset_pending", 32'(pending_o), 32'd0);
    model_reset();
    step();
    reset = 1'b0;
    steps_to_ce(0, 20, 6, "post_reset_first_ce");
    steps_to_ce(0, 20, 3, "post_reset_period3");
    for (int i = 0; i < 6; i++) step();

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
